// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - SoC-side responder for the CPU data SRAM port
// Ports:
//   clk, reset          : clock and asynchronous active-high reset
//   data_sram_en/wen    : access request and byte write enables (wen=0 is a read)
//   data_sram_addr      : byte address, [1:0] ignored
//   data_sram_wdata     : store data
//   data_sram_rdata     : registered read data, valid the cycle after the request
//   switch_in           : raw board switches
//   led, num_data       : LED and seven-segment registers
//   timer_out           : free-running timer value
module data_sram_responder #(
  parameter int          RAM_AW    = 14,
  parameter logic [15:0] CONF_BASE = 16'hBFAF,
  parameter logic [31:0] SIMU_FLAG = 32'hFFFF_FFFF,
  parameter logic [31:0] TIMER_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic [31:0] timer_out
);

  localparam logic [15:0] OFF_LED   = 16'hF000;
  localparam logic [15:0] OFF_NUM   = 16'hF010;
  localparam logic [15:0] OFF_SW    = 16'hF020;
  localparam logic [15:0] OFF_TIMER = 16'hE000;
  localparam logic [15:0] OFF_SIMU  = 16'hFFEC;

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  logic [31:0] mem [0:(1<<RAM_AW)-1];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  sw_meta_q, sw_sync_q;

  logic              conf_sel;
  logic [15:0]       conf_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              wr;
  logic              ram_we;
  logic [31:0]       conf_rdata;
  logic [31:0]       led_wr;
  logic              unused_addr;

  assign unused_addr = ^{data_sram_addr[1:0], led_wr[31:16]};

  always_comb begin
    conf_sel = (data_sram_addr[31:16] == CONF_BASE);
    conf_off = data_sram_addr[15:0];
    // Upper RAM address bits are dropped, so the RAM aliases across the space.
    ram_idx  = data_sram_addr[RAM_AW+1:2];
    wr       = data_sram_en && (data_sram_wen != 4'b0000);
    ram_we   = wr && !conf_sel;

    case (conf_off)
      OFF_LED:   conf_rdata = {16'h0000, led_q};
      OFF_NUM:   conf_rdata = num_q;
      OFF_SW:    conf_rdata = {24'h000000, sw_sync_q};
      OFF_TIMER: conf_rdata = timer_q;
      OFF_SIMU:  conf_rdata = SIMU_FLAG;
      default:   conf_rdata = 32'h0000_0000;
    endcase

    // Read-first: rdata always captures the pre-edge contents, even on writes.
    rdata_d = rdata_q;
    if (data_sram_en) rdata_d = conf_sel ? conf_rdata : mem[ram_idx];

    led_wr = byte_merge({16'h0000, led_q}, data_sram_wdata, data_sram_wen);
    led_d  = led_q;
    if (wr && conf_sel && conf_off == OFF_LED) led_d = led_wr[15:0];

    num_d = num_q;
    if (wr && conf_sel && conf_off == OFF_NUM)
      num_d = byte_merge(num_q, data_sram_wdata, data_sram_wen);

    // A software write to the timer takes priority over the increment.
    timer_d = timer_q + 32'd1;
    if (wr && conf_sel && conf_off == OFF_TIMER)
      timer_d = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= 32'h0000_0000;
      led_q     <= 16'h0000;
      num_q     <= 32'h0000_0000;
      timer_q   <= TIMER_RST;
      sw_meta_q <= 8'h00;
      sw_sync_q <= 8'h00;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      num_q     <= num_d;
      timer_q   <= timer_d;
      sw_meta_q <= switch_in;
      sw_sync_q <= sw_meta_q;
    end
  end

  // RAM contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;
  assign timer_out       = timer_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - scoreboard bench for data_sram_responder
module tb_data_sram_responder;

  logic        clk;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic [31:0] num_data;
  logic [31:0] timer_out;

  data_sram_responder dut (
    .clk             (clk),
    .reset           (reset),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .switch_in       (switch_in),
    .led             (led),
    .num_data        (num_data),
    .timer_out       (timer_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];
  logic [31:0] mem_m [int];
  logic [15:0] led_m;
  logic [31:0] num_m;
  logic [31:0] timer_m;
  logic [7:0]  sw_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int idx;
    idx = int'(a[15:2]);
    if (a[31:16] == 16'hBFAF) begin
      case (a[15:0])
        16'hF000: return {16'h0000, led_m};
        16'hF010: return num_m;
        16'hF020: return {24'h0, sw_m};
        16'hE000: return timer_m;
        16'hFFEC: return 32'hFFFF_FFFF;
        default:  return 32'h0;
      endcase
    end
    if (mem_m.exists(idx)) return mem_m[idx];
    return 32'h0;
  endfunction

  // One bus cycle: predict, push, clock, pop and compare.
  task automatic cycle(input string tag, input logic en, input logic [3:0] wen,
                       input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic [31:0] m32;
    bit          timer_wr;
    int          idx;
    data_sram_en    = en;
    data_sram_wen   = wen;
    data_sram_addr  = a;
    data_sram_wdata = wd;
    timer_wr = 1'b0;
    if (en) begin
      exp_rd = model_read(a);
      sb_q.push_back(exp_rd);
    end
    if (en && wen != 4'h0) begin
      if (a[31:16] == 16'hBFAF) begin
        case (a[15:0])
          16'hF000: begin m32 = merge({16'h0, led_m}, wd, wen); led_m = m32[15:0]; end
          16'hF010: num_m = merge(num_m, wd, wen);
          16'hE000: begin timer_m = merge(timer_m, wd, wen); timer_wr = 1'b1; end
          default: ;
        endcase
      end else begin
        idx = int'(a[15:2]);
        m32 = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        mem_m[idx] = merge(m32, wd, wen);
      end
    end
    if (!timer_wr) timer_m = timer_m + 32'd1;
    @(posedge clk);
    #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    if (en) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_empty"}, 32'h1, 32'h0);
      end else begin
        exp_rd = sb_q.pop_front();
        check(tag, data_sram_rdata, exp_rd);
      end
    end
    check({tag, "_timer"}, timer_out, timer_m);
  endtask

  initial begin
    reset = 1'b1;
    data_sram_en = 1'b0; data_sram_wen = 4'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    switch_in = 8'h00;
    led_m = 16'h0; num_m = 32'h0; timer_m = 32'h0; sw_m = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state and idle timer
    check("rst_rdata", data_sram_rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_num", num_data, 32'h0);
    check("rst_timer", timer_out, 32'h0);
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, 4'h0, 32'h0, 32'h0);
    check("t1_timer5", timer_out, 32'd5);
    check("t1_rdata", data_sram_rdata, 32'h0);

    // 2: RAM full and partial writes, en=0 write suppression, aliasing
    cycle("t2_wr", 1'b1, 4'hF, 32'h0000_0010, 32'hDEADBEEF);
    cycle("t2_rd", 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("t2_rd_const", data_sram_rdata, 32'hDEADBEEF);
    cycle("t2_pwr", 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_5500);
    check("t2_pwr_old", data_sram_rdata, 32'hDEADBEEF);
    cycle("t2_rd2", 1'b1, 4'h0, 32'h0000_0010, 32'h0);
    check("t2_rd2_const", data_sram_rdata, 32'hDEAD55EF);
    cycle("t2_nowr", 1'b0, 4'hF, 32'h0000_0010, 32'h1111_1111);
    check("t2_hold", data_sram_rdata, 32'hDEAD55EF);
    cycle("t2_alias", 1'b1, 4'h0, 32'h0001_0010, 32'h0);

    // 3: config registers
    cycle("t3_led_wr", 1'b1, 4'hF, 32'hBFAF_F000, 32'h1234_ABCD);
    check("t3_led", {16'h0, led}, 32'h0000_ABCD);
    cycle("t3_led_rd", 1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
    check("t3_led_rd_const", data_sram_rdata, 32'h0000_ABCD);
    cycle("t3_num_wr", 1'b1, 4'b0101, 32'hBFAF_F010, 32'hA1B2_C3D4);
    check("t3_num", num_data, 32'h00B2_00D4);
    cycle("t3_sw_wr", 1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFF);
    cycle("t3_sw_rd", 1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    cycle("t3_simu", 1'b1, 4'h0, 32'hBFAF_FFEC, 32'h0);
    check("t3_simu_const", data_sram_rdata, 32'hFFFF_FFFF);
    cycle("t3_hole", 1'b1, 4'hF, 32'hBFAF_F004, 32'h5555_5555);
    cycle("t3_hole_rd", 1'b1, 4'h0, 32'hBFAF_F004, 32'h0);

    // 4: timer load and wrap
    cycle("t4_tw", 1'b1, 4'hF, 32'hBFAF_E000, 32'h0000_0100);
    check("t4_n1", timer_out, 32'h100);
    cycle("t4_idle", 1'b0, 4'h0, 32'h0, 32'h0);
    check("t4_n2", timer_out, 32'h101);
    cycle("t4_trd", 1'b1, 4'h0, 32'hBFAF_E000, 32'h0);
    check("t4_trd_const", data_sram_rdata, 32'h101);
    cycle("t4_tmax", 1'b1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFF);
    cycle("t4_wrap", 1'b0, 4'h0, 32'h0, 32'h0);
    check("t4_wrap_const", timer_out, 32'h0);

    // 5: switch synchronizer delay
    switch_in = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      sw_m = (k < 2) ? 8'h00 : 8'hA5;
      cycle("t5_sw", 1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    end
    sw_m = 8'hA5;

    // 6: back-to-back traffic with reset during the third read
    for (int w = 0; w < 4; w++)
      cycle("t6_wr", 1'b1, 4'hF, 32'(w * 4), 32'hC0DE_0000 + 32'(w));
    cycle("t6_rd0", 1'b1, 4'h0, 32'h0, 32'h0);
    cycle("t6_rd1", 1'b1, 4'h0, 32'h4, 32'h0);
    data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h8;
    #2 reset = 1'b1;
    #1 check("t6_async_led", {16'h0, led}, 32'h0);
    check("t6_async_rdata", data_sram_rdata, 32'h0);
    @(posedge clk);
    #1;
    data_sram_en = 1'b0;
    reset = 1'b0;
    led_m = 16'h0; num_m = 32'h0; timer_m = 32'h0; sw_m = 8'h00;
    check("t6_rst_rdata", data_sram_rdata, 32'h0);
    check("t6_rst_num", num_data, 32'h0);
    cycle("t6_post_idle", 1'b0, 4'h0, 32'h0, 32'h0);
    check("t6_post_rdata", data_sram_rdata, 32'h0);
    sw_m = 8'hA5;
    cycle("t6_rd3", 1'b1, 4'h0, 32'hC, 32'h0);
    check("t6_rd3_const", data_sram_rdata, 32'hC0DE_0003);
    for (int w = 0; w < 3; w++)
      cycle("t6_reread", 1'b1, 4'h0, 32'(w * 4), 32'h0);
    check("t6_sb_drained", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
